mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single memory port between two requesters: instruction fetch (port 0) and the load/store memory controller (port 1). Issues at most one access per cycle to memory. Tracks in-flight reads through a fixed-latency tag pipeline so each read response returns to the requester that issued it. Sits between the core's fetch/memory-controller blocks and the memory model or SRAM wrapper.

## Interface
- READ_LATENCY, 1: cycles from an issued read to `read_data` being valid; legal range 1..4.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte enables are DATA_W/8 wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0 / req1  in  1  requester has a pending access.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  DATA_W  write data.
- be0 / be1  in  DATA_W/8  byte enables.
- gnt0 / gnt1  out  1  access accepted this cycle.
- rvalid0 / rvalid1  out  1  read response valid this cycle.
- rdata0 / rdata1  out  DATA_W  read response data.
- address  out  ADDR_W  memory address.
- read_enable  out  1  memory read strobe.
- write_enable  out  1  memory write strobe.
- write_data  out  DATA_W  memory write data.
- byte_enables  out  DATA_W/8  memory byte enables.
- read_data  in  DATA_W  memory read data, valid READ_LATENCY cycles after read_enable.

## Operation
- **Request/grant handshake**
  - A requester holds req and all attributes stable until it sees gnt.
  - gnt is combinational in the same cycle the access drives the memory strobes.
  - Handshake completes when req and gnt are both high on a clock edge.
- **Arbitration (default round-robin)**
  - Register `last_gnt` resets to 1, so port 0 wins the first contention.
  - When only one port requests, that port is granted.
  - When both request, the port not equal to `last_gnt` is granted.
  - `last_gnt` updates only on a grant.
- **Memory drive**
  - The granted port's addr, wdata and be are muxed onto the memory outputs.
  - Read grant: read_enable=1. Write grant: write_enable=1. Never both.
  - With no grant, both enables are 0 and address/write_data/byte_enables are 0.
- **Tag pipeline**
  - READ_LATENCY stages of {valid, port}.
  - Stage 0 is loaded with {read grant, granted port}.
  - The stage READ_LATENCY-1 output drives rvalidN = valid && port==N.
  - rdataN = read_data when rvalidN is high, otherwise 0.
- **Writes** produce no response; completion is the grant.
- **Back-to-back grants** are allowed every cycle. Up to READ_LATENCY reads may be in flight; there is no stall.
- **Reset**
  - rst flushes all tag-pipeline valid bits.
  - Reads in flight at reset never produce rvalid.
  - While rst is high, gnt0, gnt1, read_enable and write_enable are forced to 0.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the request cycle when the port wins.
- Read response: rvalid is high exactly READ_LATENCY cycles after the grant edge, for one cycle.
- Reset values:
  - gnt0, gnt1, rvalid0, rvalid1, read_enable, write_enable = 0.
  - rdata0, rdata1, address, write_data, byte_enables = 0.
  - last_gnt = 1.
- Simultaneous events:
  - A new grant and an rvalid for an older read in the same cycle are independent.
  - Deasserting req in the cycle it would be granted is illegal; behaviour is undefined and flagged by an assertion.

## Configuration
- Macro: `MEM_ARB_DATA_PRIO_EN`.
- Defined: fixed priority. Port 1 (data) always wins contention, port 0 is granted only when req1=0, and last_gnt is unused.
- Undefined: round-robin as described above.

## Structure
- **Shared package `mem_pkg`** (alongside `opcodes`) holds:
  - `mem_port_e` enum: PORT_IFETCH=0, PORT_DATA=1.
  - `mem_tag_t` struct: {valid, mem_port_e port}.
  - Constant MEM_ARB_MAX_LATENCY=4.
- **Sub-module `mem_arb_tag_pipe`**: parameterised shift register of mem_tag_t with a synchronous flush. Instantiated once.

## Test plan
- Port 0 only: read addr 0x100, READ_LATENCY=2 -> gnt0 same cycle, read_enable=1, address=0x100; rvalid0=1 two cycles later with rdata0 equal to memory word; rvalid1 stays 0.
- Contention after reset: both ports request reads, addr0=0x10, addr1=0x20, held -> grants alternate 0,1,0,1; responses return in the same order to the matching port.
- Write: port 1 writes wdata=0xDEADBEEF, be=4'b0011 to 0x40 -> write_enable=1, byte_enables=0011, no rvalid; a later port 0 read of 0x40 returns 0x0000BEEF over a zeroed memory.
- Back-to-back reads: READ_LATENCY=3, 3 consecutive port 1 reads -> three consecutive rvalid1 pulses starting 3 cycles after the first grant.
- Reset mid-flight: rst asserted one cycle after a read grant -> no rvalid for that read; all outputs at reset values the cycle after rst.
- With `MEM_ARB_DATA_PRIO_EN`: both ports request continuously for 5 cycles -> gnt1 all 5 cycles, gnt0 never.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-bus types: requester port identifiers, read-tag records and latency limit.
package mem_pkg;

  typedef enum logic {
    PORT_IFETCH = 1'b0,
    PORT_DATA   = 1'b1
  } mem_port_e;

  typedef struct packed {
    logic      valid;
    mem_port_e port;
  } mem_tag_t;

  localparam int MEM_ARB_MAX_LATENCY = 4;

  function automatic mem_port_e other_port(input mem_port_e p);
    return (p == PORT_IFETCH) ? PORT_DATA : PORT_IFETCH;
  endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Fixed-depth shift register of read tags; a synchronous flush clears only the valid bits.
module mem_arb_tag_pipe
  import mem_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  mem_tag_t tag_in,
  output mem_tag_t tag_out
);

  logic      [STAGES-1:0] vld_p;
  mem_port_e              port_p [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= tag_in.valid;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Port ids are qualified by vld_p, so they need no reset.
  always_ff @(posedge clk) begin
    port_p[0] <= tag_in.port;
    for (int i = 1; i < STAGES; i++) begin
      port_p[i] <= port_p[i-1];
    end
  end

  assign tag_out.valid = vld_p[STAGES-1];
  assign tag_out.port  = port_p[STAGES-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory arbiter (ifetch / data) with a fixed-latency read-tag pipeline.
// Define MEM_ARB_DATA_PRIO_EN for fixed data-port priority instead of round-robin.
module mem_bus_arbiter
  import mem_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W/8-1:0] be0,
  input  logic                req1,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] be1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic [ADDR_W-1:0]   address,
  output logic                read_enable,
  output logic                write_enable,
  output logic [DATA_W-1:0]   write_data,
  output logic [DATA_W/8-1:0] byte_enables,
  input  logic [DATA_W-1:0]   read_data
);

  logic     grant0;
  logic     grant1;
  mem_tag_t tag_issue;
  mem_tag_t tag_resp;

`ifdef MEM_ARB_DATA_PRIO_EN
  always_comb begin
    grant0 = !rst && req0 && !req1;
    grant1 = !rst && req1;
  end
`else
  mem_port_e last_gnt;
  mem_port_e rr_pick;

  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    rr_pick = other_port(last_gnt);
    if (!rst) begin
      if (req0 && req1) begin
        grant0 = (rr_pick == PORT_IFETCH);
        grant1 = (rr_pick == PORT_DATA);
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= PORT_DATA;
    end else if (grant0) begin
      last_gnt <= PORT_IFETCH;
    end else if (grant1) begin
      last_gnt <= PORT_DATA;
    end
  end
`endif

  assign gnt0 = grant0;
  assign gnt1 = grant1;

  // Granted port drives the memory; idle cycles present an all-zero bus.
  always_comb begin
    address         = '0;
    write_data      = '0;
    byte_enables    = '0;
    read_enable     = 1'b0;
    write_enable    = 1'b0;
    tag_issue.valid = 1'b0;
    tag_issue.port  = PORT_IFETCH;
    if (grant0) begin
      address         = addr0;
      write_data      = wdata0;
      byte_enables    = be0;
      read_enable     = !we0;
      write_enable    = we0;
      tag_issue.valid = !we0;
      tag_issue.port  = PORT_IFETCH;
    end else if (grant1) begin
      address         = addr1;
      write_data      = wdata1;
      byte_enables    = be1;
      read_enable     = !we1;
      write_enable    = we1;
      tag_issue.valid = !we1;
      tag_issue.port  = PORT_DATA;
    end
  end

  mem_arb_tag_pipe #(
    .STAGES (READ_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_issue),
    .tag_out (tag_resp)
  );

  // rst also masks the pipe output so a read issued just before reset is never answered.
  always_comb begin
    rvalid0 = !rst && tag_resp.valid && (tag_resp.port == PORT_IFETCH);
    rvalid1 = !rst && tag_resp.valid && (tag_resp.port == PORT_DATA);
    rdata0  = rvalid0 ? read_data : '0;
    rdata1  = rvalid1 ? read_data : '0;
  end

  a_latency_range: assert property (@(posedge clk)
    (READ_LATENCY >= 1) && (READ_LATENCY <= MEM_ARB_MAX_LATENCY));
  a_one_strobe: assert property (@(posedge clk) !(read_enable && write_enable));
  a_req0_hold: assert property (@(posedge clk) disable iff (rst)
    (req0 && !gnt0) |=> req0);
  a_req1_hold: assert property (@(posedge clk) disable iff (rst)
    (req1 && !gnt1) |=> req1);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner sequences, random traffic.
module tb_mem_bus_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1, address, write_data, read_data;
  logic        read_enable, write_enable;
  logic [3:0]  byte_enables;

  mem_bus_arbiter #(
    .READ_LATENCY (LAT),
    .ADDR_W       (32),
    .DATA_W       (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .be0          (be0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .be1          (be1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .address      (address),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .write_data   (write_data),
    .byte_enables (byte_enables),
    .read_data    (read_data)
  );

  always #5 clk = ~clk;

  // Memory environment: byte-masked writes, reads answered LAT cycles later, noise otherwise.
  logic [31:0] mem_arr [256] = '{default: '0};
  logic [31:0] rd_pipe [LAT] = '{default: '0};
  logic        rv_pipe [LAT] = '{default: 1'b0};
  logic [31:0] junk = 32'h0;

  always @(posedge clk) begin
    if (write_enable) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enables[b]) mem_arr[address[9:2]][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
    rv_pipe[0] <= read_enable;
    rd_pipe[0] <= mem_arr[address[9:2]];
    for (int i = 1; i < LAT; i++) begin
      rv_pipe[i] <= rv_pipe[i-1];
      rd_pipe[i] <= rd_pipe[i-1];
    end
    junk <= $urandom;
  end

  assign read_data = rv_pipe[LAT-1] ? rd_pipe[LAT-1] : junk;

  // Reference model: arbitration rule, byte-level memory image, queue of due responses.
  typedef struct {
    int          due;
    logic        port;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] model_mem [256] = '{default: '0};
  logic        m_last = 1'b1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        g0s, g1s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic model_cycle();
    logic        e_g0, e_g1, e_re, e_we, e_rv0, e_rv1, wp, wwe;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    logic [3:0]  e_be;
    resp_t       r;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!rst) begin
`ifdef MEM_ARB_DATA_PRIO_EN
      e_g1 = req1;
      e_g0 = req0 && !req1;
`else
      if (req0 && req1) begin
        e_g0 = (m_last == 1'b1);
        e_g1 = !e_g0;
      end else begin
        e_g0 = req0;
        e_g1 = req1;
      end
`endif
    end
    wp     = e_g1;
    wwe    = wp ? we1 : we0;
    e_re   = (e_g0 || e_g1) && !wwe;
    e_we   = (e_g0 || e_g1) && wwe;
    e_addr = e_g0 ? addr0 : (e_g1 ? addr1 : 32'h0);
    e_wd   = e_g0 ? wdata0 : (e_g1 ? wdata1 : 32'h0);
    e_be   = e_g0 ? be0 : (e_g1 ? be1 : 4'h0);
    e_rv0  = 1'b0;
    e_rv1  = 1'b0;
    e_rd0  = 32'h0;
    e_rd1  = 32'h0;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      if (r.port) begin
        e_rv1 = 1'b1;
        e_rd1 = r.data;
      end else begin
        e_rv0 = 1'b1;
        e_rd0 = r.data;
      end
    end
    g0s = gnt0;
    g1s = gnt1;
    chk("gnt0", 32'(gnt0), 32'(e_g0));
    chk("gnt1", 32'(gnt1), 32'(e_g1));
    chk("read_enable", 32'(read_enable), 32'(e_re));
    chk("write_enable", 32'(write_enable), 32'(e_we));
    chk("address", address, e_addr);
    chk("write_data", write_data, e_wd);
    chk("byte_enables", 32'(byte_enables), 32'(e_be));
    chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
    if (rst) m_last = 1'b1;
    else if (e_g0) m_last = 1'b0;
    else if (e_g1) m_last = 1'b1;
    if (e_we) model_mem[e_addr[9:2]] = merge(model_mem[e_addr[9:2]], e_wd, e_be);
    if (e_re) begin
      r.due  = cyc + LAT;
      r.port = wp;
      r.data = model_mem[e_addr[9:2]];
      exp_q.push_back(r);
    end
    cyc++;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; be0 = 4'hF;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; be1 = 4'hF;
  endtask

  // ctl = {rst, req0, we0, req1, we1}; exp = {gnt0, gnt1, rvalid0, rvalid1}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [3:0]  be1;
    logic [3:0]  exp;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{5'b10000, 32'h0,   32'h0,  32'h0,        4'h0,    4'b0000, 32'h0, 32'h0};
    vecs[1]  = '{5'b01000, 32'h100, 32'h0,  32'h0,        4'h0,    4'b1000, 32'h0, 32'h0};
    vecs[2]  = '{5'b00000, 32'h0,   32'h0,  32'h0,        4'h0,    4'b0000, 32'h0, 32'h0};
    vecs[3]  = '{5'b00000, 32'h0,   32'h0,  32'h0,        4'h0,    4'b0010, 32'h0, 32'h0};
    vecs[4]  = '{5'b10000, 32'h0,   32'h0,  32'h0,        4'h0,    4'b0000, 32'h0, 32'h0};
    vecs[5]  = '{5'b01010, 32'h10,  32'h20, 32'h0,        4'h0,    4'b1000, 32'h0, 32'h0};
    vecs[6]  = '{5'b01010, 32'h10,  32'h20, 32'h0,        4'h0,    4'b0100, 32'h0, 32'h0};
    vecs[7]  = '{5'b01010, 32'h10,  32'h20, 32'h0,        4'h0,    4'b1010, 32'h0, 32'h0};
    vecs[8]  = '{5'b01010, 32'h10,  32'h20, 32'h0,        4'h0,    4'b0101, 32'h0, 32'h0};
    vecs[9]  = '{5'b01000, 32'h10,  32'h0,  32'h0,        4'h0,    4'b1010, 32'h0, 32'h0};
    vecs[10] = '{5'b00000, 32'h0,   32'h0,  32'h0,        4'h0,    4'b0001, 32'h0, 32'h0};
    vecs[11] = '{5'b00011, 32'h0,   32'h40, 32'hDEADBEEF, 4'b0011, 4'b0110, 32'h0, 32'h0};
    vecs[12] = '{5'b01000, 32'h40,  32'h0,  32'h0,        4'h0,    4'b1000, 32'h0, 32'h0};
    vecs[13] = '{5'b00000, 32'h0,   32'h0,  32'h0,        4'h0,    4'b0000, 32'h0, 32'h0};
    vecs[14] = '{5'b00000, 32'h0,   32'h0,  32'h0,        4'h0,    4'b0010, 32'h0000BEEF, 32'h0};

    idle_inputs();
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      rst    = vecs[i].ctl[4];
      req0   = vecs[i].ctl[3];
      we0    = vecs[i].ctl[2];
      req1   = vecs[i].ctl[1];
      we1    = vecs[i].ctl[0];
      addr0  = vecs[i].addr0;
      addr1  = vecs[i].addr1;
      wdata1 = vecs[i].wdata1;
      be1    = vecs[i].be1;
      @(negedge clk);
      model_cycle();
`ifndef MEM_ARB_DATA_PRIO_EN
      chk($sformatf("vec%0d gnt0", i), 32'(gnt0), 32'(vecs[i].exp[3]));
      chk($sformatf("vec%0d gnt1", i), 32'(gnt1), 32'(vecs[i].exp[2]));
      chk($sformatf("vec%0d rvalid0", i), 32'(rvalid0), 32'(vecs[i].exp[1]));
      chk($sformatf("vec%0d rvalid1", i), 32'(rvalid1), 32'(vecs[i].exp[0]));
      chk($sformatf("vec%0d rdata0", i), rdata0, vecs[i].rd0);
      chk($sformatf("vec%0d rdata1", i), rdata1, vecs[i].rd1);
`endif
      next_edge();
    end

    // Back-to-back port 1 reads: one rvalid1 pulse per read, LAT cycles after each grant.
    idle_inputs();
    for (int k = 0; k < LAT + 4; k++) begin
      req1  = (k < 3);
      addr1 = 32'(4 * (k + 1));
      @(negedge clk);
      model_cycle();
      chk("b2b gnt1", 32'(gnt1), 32'(k < 3));
      chk("b2b rvalid1", 32'(rvalid1), 32'((k >= LAT) && (k < LAT + 3)));
      next_edge();
    end

    // Reset one cycle after a read grant: that read must never be answered.
    idle_inputs();
    req0  = 1'b1;
    addr0 = 32'h8;
    @(negedge clk);
    model_cycle();
    chk("rstmid gnt0", 32'(gnt0), 32'h1);
    next_edge();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    model_cycle();
    next_edge();
    rst = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      model_cycle();
      chk("rstmid rvalid0", 32'(rvalid0), 32'h0);
      chk("rstmid address", address, 32'h0);
      next_edge();
    end

    // Five cycles of continuous contention from a freshly reset arbiter.
    req0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b1; addr1 = 32'h20;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      model_cycle();
`ifdef MEM_ARB_DATA_PRIO_EN
      chk("prio gnt1", 32'(gnt1), 32'h1);
      chk("prio gnt0", 32'(gnt0), 32'h0);
`else
      chk("rr gnt0", 32'(gnt0), 32'((k % 2) == 0));
      chk("rr gnt1", 32'(gnt1), 32'((k % 2) == 1));
`endif
      next_edge();
    end
    req0 = !g0s;
    req1 = !g1s;
    @(negedge clk);
    model_cycle();
    next_edge();

    // Random traffic; a pending request is held with its attributes until granted.
    idle_inputs();
    g0s = 1'b1;
    g1s = 1'b1;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!(req0 && !g0s)) begin
        req0   = ($urandom_range(0, 9) < 6);
        we0    = ($urandom_range(0, 3) == 0);
        addr0  = 32'($urandom_range(0, 63)) << 2;
        wdata0 = $urandom;
        be0    = 4'($urandom);
      end
      if (!(req1 && !g1s)) begin
        req1   = ($urandom_range(0, 9) < 6);
        we1    = ($urandom_range(0, 2) == 0);
        addr1  = 32'($urandom_range(0, 63)) << 2;
        wdata1 = $urandom;
        be1    = 4'($urandom);
      end
      @(negedge clk);
      model_cycle();
      next_edge();
    end

    // Drain the last in-flight reads without leaving a pending request ungranted.
    rst = 1'b0;
    req0 = req0 && !g0s;
    req1 = req1 && !g1s;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      model_cycle();
      next_edge();
      if (g0s) req0 = 1'b0;
      if (g1s) req1 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
